// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: opcodes, FSM encoding, default widths.
package alu_arbiter_pkg;

    localparam int W_DEF   = 4;
    localparam int OPW_DEF = 3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NOTB = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after last, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx
);

    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        win     = '0;
        win_idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one external ALU among N requesters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = W_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*OPW-1:0] op_in,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_carry,
    input  logic           alu_borrow,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_carry,
    output logic           rsp_borrow,
    output logic           busy,
    output logic [7:0]     op_count
);

    localparam int IW = $clog2(N);

    logic [1:0]    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    int            sel;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req     (req),
        .last    (last_grant),
        .win     (pick_oh),
        .win_idx (pick_idx)
    );

    assign sel  = int'(pick_idx);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= IW'(N - 1);
            grant_idx  <= '0;
            grant      <= '0;
            done       <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_borrow <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    if (|req) begin
                        grant     <= pick_oh;
                        grant_idx <= pick_idx;
                        alu_op    <= op_in[sel*OPW +: OPW];
                        alu_a     <= a_in[sel*W +: W];
                        alu_b     <= b_in[sel*W +: W];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
                    rsp_borrow <= alu_borrow;
                    done       <= grant;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    done       <= '0;
                    grant      <= '0;
                    last_grant <= grant_idx;
                    op_count   <= op_count + 8'd1;
                    state      <= S_IDLE;
                end
                default: begin
                    done  <= '0;
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU attached.
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int OPW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*OPW-1:0] op_in;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;
    logic           alu_carry;
    logic           alu_borrow;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
    logic           rsp_borrow;
    logic           busy;
    logic [7:0]     op_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .W(W), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .req(req),
        .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_borrow(alu_borrow),
        .grant(grant), .done(done),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_borrow(rsp_borrow),
        .busy(busy), .op_count(op_count)
    );

    // External shared ALU
    always_comb begin
        logic [W:0] s;
        s          = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_borrow = 1'b0;
        case (alu_op)
            3'd0: begin
                s          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = s[W-1:0];
                alu_carry  = s[W];
            end
            3'd1: begin
                alu_result = alu_a - alu_b;
                alu_borrow = (alu_a < alu_b);
            end
            3'd2: alu_result = ~alu_a;
            3'd3: alu_result = ~alu_b;
            3'd4: alu_result = alu_a & alu_b;
            3'd5: alu_result = alu_a | alu_b;
            3'd6: alu_result = alu_a ^ alu_b;
            default: alu_result = ~(alu_a ^ alu_b);
        endcase
    end

    typedef struct {
        int         idx;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       bw;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_opnd(input int i, input logic [2:0] op,
                            input logic [3:0] a, input logic [3:0] b);
        op_in[i*OPW +: OPW] = op;
        a_in[i*W +: W]      = a;
        b_in[i*W +: W]      = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
    endtask

    // Single request from IDLE, checked cycle by cycle
    task automatic run_op(input vec_t v);
        logic [N-1:0] oh;
        oh = '0;
        oh[v.idx] = 1'b1;
        @(negedge clk);
        set_opnd(v.idx, v.op, v.a, v.b);
        req[v.idx] = 1'b1;
        @(negedge clk);
        chk("grant", 32'(grant), 32'(oh));
        chk("busy_issue", 32'(busy), 32'd1);
        chk("no_early_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("done", 32'(done), 32'(oh));
        chk("result", 32'(rsp_result), 32'(v.res));
        chk("carry", 32'(rsp_carry), 32'(v.c));
        chk("borrow", 32'(rsp_borrow), 32'(v.bw));
        req[v.idx] = 1'b0;
        @(negedge clk);
        exp_count++;
        chk("done_clear", 32'(done), 32'd0);
        chk("grant_clear", 32'(grant), 32'd0);
        chk("op_count", 32'(op_count), 32'(8'(exp_count)));
        chk("rsp_hold", 32'(rsp_result), 32'(v.res));
    endtask

    initial begin
        logic [N-1:0] oh;
        logic [3:0]   rr_res [4];
        logic         rr_c   [4];
        logic         rr_b   [4];
        int           n;

        vecs[0]  = '{0, 3'd0, 4'd9,  4'd8,  4'd1,  1'b1, 1'b0};
        vecs[1]  = '{1, 3'd1, 4'd3,  4'd5,  4'd14, 1'b0, 1'b1};
        vecs[2]  = '{2, 3'd2, 4'd5,  4'd0,  4'd10, 1'b0, 1'b0};
        vecs[3]  = '{3, 3'd3, 4'd0,  4'd6,  4'd9,  1'b0, 1'b0};
        vecs[4]  = '{0, 3'd4, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0};
        vecs[5]  = '{1, 3'd5, 4'd12, 4'd10, 4'd14, 1'b0, 1'b0};
        vecs[6]  = '{2, 3'd6, 4'd12, 4'd10, 4'd6,  1'b0, 1'b0};
        vecs[7]  = '{3, 3'd7, 4'd12, 4'd10, 4'd9,  1'b0, 1'b0};
        vecs[8]  = '{0, 3'd0, 4'd15, 4'd1,  4'd0,  1'b1, 1'b0};
        vecs[9]  = '{1, 3'd1, 4'd5,  4'd3,  4'd2,  1'b0, 1'b0};
        vecs[10] = '{2, 3'd0, 4'd7,  4'd8,  4'd15, 1'b0, 1'b0};
        vecs[11] = '{3, 3'd1, 4'd8,  4'd8,  4'd0,  1'b0, 1'b0};

        rst   = 1'b1;
        req   = '0;
        op_in = '0;
        a_in  = '0;
        b_in  = '0;
        #12;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) run_op(vecs[k]);

        // Reset while in ISSUE discards the operation
        @(negedge clk);
        set_opnd(1, 3'd0, 4'd4, 4'd4);
        req[1] = 1'b1;
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_result), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        req = '0;
        exp_count = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        run_op('{2, 3'd0, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0});

        // All four requesting continuously, starting from reset priority
        do_reset();
        set_opnd(0, 3'd0, 4'd1,  4'd3);
        set_opnd(1, 3'd1, 4'd2,  4'd5);
        set_opnd(2, 3'd6, 4'd3,  4'd7);
        set_opnd(3, 3'd0, 4'd12, 4'd9);
        rr_res[0] = 4'd4;  rr_c[0] = 1'b0; rr_b[0] = 1'b0;
        rr_res[1] = 4'd13; rr_c[1] = 1'b0; rr_b[1] = 1'b1;
        rr_res[2] = 4'd4;  rr_c[2] = 1'b0; rr_b[2] = 1'b0;
        rr_res[3] = 4'd5;  rr_c[3] = 1'b1; rr_b[3] = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = '0;
            oh[k % 4] = 1'b1;
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(oh));
            @(negedge clk);
            chk("rr_done", 32'(done), 32'(oh));
            chk("rr_result", 32'(rsp_result), 32'(rr_res[k % 4]));
            chk("rr_carry", 32'(rsp_carry), 32'(rr_c[k % 4]));
            chk("rr_borrow", 32'(rsp_borrow), 32'(rr_b[k % 4]));
            if (k == 4) req = '0;
            @(negedge clk);
            chk("rr_idle_busy", 32'(busy), 32'd0);
        end
        exp_count = 5;
        chk("rr_count", 32'(op_count), 32'd5);

        // Wrap priority: after requester 2, req 3 and 0 together
        run_op('{2, 3'd4, 4'd15, 4'd3, 4'd3, 1'b0, 1'b0});
        @(negedge clk);
        set_opnd(0, 3'd5, 4'd1, 4'd2);
        set_opnd(3, 3'd6, 4'd1, 4'd3);
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_first", 32'(grant), 32'd8);
        @(negedge clk);
        chk("wrap_first_res", 32'(rsp_result), 32'd2);
        req[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_second", 32'(grant), 32'd1);
        @(negedge clk);
        chk("wrap_second_done", 32'(done), 32'd1);
        chk("wrap_second_res", 32'(rsp_result), 32'd3);
        req[0] = 1'b0;
        @(negedge clk);
        exp_count += 2;

        // Operand change during ISSUE must not disturb the operation
        set_opnd(0, 3'd0, 4'd2, 4'd3);
        req[0] = 1'b1;
        @(negedge clk);
        set_opnd(0, 3'd0, 4'd15, 4'd15);
        @(negedge clk);
        chk("stable_alu_a", 32'(alu_a), 32'd2);
        chk("stable_result", 32'(rsp_result), 32'd5);
        req[0] = 1'b0;
        @(negedge clk);
        exp_count++;
        chk("stable_count", 32'(op_count), 32'(8'(exp_count)));

        // Counter wrap back to 0
        n = 256 - (exp_count % 256);
        set_opnd(1, 3'd0, 4'd1, 4'd1);
        req[1] = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            @(negedge clk);
            if (j == n - 1) req[1] = 1'b0;
            @(negedge clk);
        end
        chk("count_wrap", 32'(op_count), 32'd0);
        chk("wrap_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

endmodule
